from_usb: RTL

Receive-side line decoder for the USB thumb-drive link. It samples the differential pair (d_p, d_m) once per clock and classifies each sample as SE0, J, K or SE1. It then frames packets (SOP K, data symbols, EOP = SE0, SE0, J), recovers the serial bit stream (J = 1, K = 0) and assembles LSB-first bytes for the upstream packet logic. It is the counterpart of the transmit controller and uses the same one-symbol-per-clock line encoding.

---
 rtl/usb_pkg.sv | 29 ++
 rtl/usb_rx_shift.sv | 36 +++
 rtl/from_usb.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/usb_pkg.sv
// Shared USB line-level definitions: symbol encoding, bit mapping,
// EOP length and receiver states. Imported by the rx and tx paths.
package usb_pkg;

  // {d_p, d_m} encoding of one line sample
  typedef enum logic [1:0] {
    SE0 = 2'b00,
    K   = 2'b01,
    J   = 2'b10,
    SE1 = 2'b11
  } sym_t;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    EOP1,
    EOP2,
    ERR
  } rx_state_t;

  localparam logic BIT_J   = 1'b1;
  localparam logic BIT_K   = 1'b0;
  localparam int   EOP_LEN = 2;

  function automatic logic sym_bit(input sym_t s);
    return (s == J) ? BIT_J : BIT_K;
  endfunction

endpackage

// File: rtl/usb_rx_shift.sv
// LSB-first byte assembler: 8-bit shift register plus 3-bit bit counter.
// Ports: clk, rst, clear, shift_en, bit_in -> rx_data, done, partial.
module usb_rx_shift (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       shift_en,
  input  logic       bit_in,
  output logic [7:0] rx_data,
  output logic       done,
  output logic       partial
);

  logic [7:0] sr;
  logic [2:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr  <= 8'h00;
      cnt <= 3'd0;
    end else if (clear) begin
      sr  <= 8'h00;
      cnt <= 3'd0;
    end else if (shift_en) begin
      sr  <= {bit_in, sr[7:1]};
      cnt <= cnt + 3'd1;
    end
  end

  // Byte as it will look once the current bit is shifted in, so the
  // parent can register it in the same cycle as the 8th bit.
  assign rx_data = {bit_in, sr[7:1]};
  assign done    = shift_en && (cnt == 3'd7);
  assign partial = (cnt != 3'd0);

endmodule

// File: rtl/from_usb.sv
// USB receive line decoder: frames packets, recovers bits and bytes.
// Ports: clk, rst, d_p, d_m -> data_bit, bit_valid, rx_byte, byte_valid,
// pkt_start, pkt_end, pkt_partial, rx_err, busy.
// Optional macro FROM_USB_LEN_CHECK_EN enables the MAX_BITS length limit.
module from_usb
  import usb_pkg::*;
#(
  parameter int MAX_BITS = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_p,
  input  logic       d_m,
  output logic       data_bit,
  output logic       bit_valid,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       pkt_start,
  output logic       pkt_end,
  output logic       pkt_partial,
  output logic       rx_err,
  output logic       busy
);

  if (MAX_BITS < 1) begin : g_bad_max_bits
    $error("MAX_BITS must be at least 1");
  end

  rx_state_t  state;
  sym_t       line_q;
  logic [1:0] se0_cnt;
  logic       is_data;
  logic       len_over;
  logic       shift_en;
  logic       clear;
  logic [7:0] sh_data;
  logic       sh_done;
  logic       sh_partial;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) line_q <= SE0;
    else     line_q <= sym_t'({d_p, d_m});
  end

  assign is_data  = (line_q == J) || (line_q == K);
  assign clear    = (state == IDLE) && (line_q == K);
  assign shift_en = (state == RECV) && is_data && !len_over;

`ifdef FROM_USB_LEN_CHECK_EN
  localparam int LW = $clog2(MAX_BITS + 1);
  logic [LW-1:0] bit_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           bit_cnt <= '0;
    else if (clear)    bit_cnt <= '0;
    else if (shift_en) bit_cnt <= bit_cnt + LW'(1);
  end

  assign len_over = (bit_cnt == LW'(MAX_BITS));
`else
  assign len_over = 1'b0;
`endif

  usb_rx_shift u_shift (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .shift_en (shift_en),
    .bit_in   (sym_bit(line_q)),
    .rx_data  (sh_data),
    .done     (sh_done),
    .partial  (sh_partial)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      se0_cnt     <= 2'd0;
      data_bit    <= 1'b0;
      bit_valid   <= 1'b0;
      rx_byte     <= 8'h00;
      byte_valid  <= 1'b0;
      pkt_start   <= 1'b0;
      pkt_end     <= 1'b0;
      pkt_partial <= 1'b0;
      rx_err      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      data_bit    <= 1'b0;
      bit_valid   <= 1'b0;
      byte_valid  <= 1'b0;
      pkt_start   <= 1'b0;
      pkt_end     <= 1'b0;
      pkt_partial <= 1'b0;
      rx_err      <= 1'b0;
      // SE0 run length only matters inside ERR; restart it on entry
      if (state != ERR) se0_cnt <= 2'd0;
      unique case (state)
        IDLE: begin
          if (line_q == K) begin
            state     <= RECV;
            pkt_start <= 1'b1;
            busy      <= 1'b1;
          end else if (line_q == SE1) begin
            state  <= ERR;
            rx_err <= 1'b1;
            busy   <= 1'b1;
          end
        end
        RECV: begin
          if (is_data && len_over) begin
            state  <= ERR;
            rx_err <= 1'b1;
          end else if (is_data) begin
            bit_valid <= 1'b1;
            data_bit  <= sym_bit(line_q);
            if (sh_done) begin
              rx_byte    <= sh_data;
              byte_valid <= 1'b1;
            end
          end else if (line_q == SE0) begin
            state <= EOP1;
          end else begin
            state  <= ERR;
            rx_err <= 1'b1;
          end
        end
        EOP1: begin
          if (line_q == SE0) begin
            state <= EOP2;
          end else begin
            state  <= ERR;
            rx_err <= 1'b1;
          end
        end
        EOP2: begin
          if (line_q == J) begin
            state       <= IDLE;
            pkt_end     <= 1'b1;
            pkt_partial <= sh_partial;
            busy        <= 1'b0;
          end else begin
            state  <= ERR;
            rx_err <= 1'b1;
          end
        end
        ERR: begin
          if (line_q != SE0) begin
            se0_cnt <= 2'd0;
          end else if (se0_cnt == 2'(EOP_LEN - 1)) begin
            state   <= IDLE;
            se0_cnt <= 2'd0;
            busy    <= 1'b0;
          end else begin
            se0_cnt <= se0_cnt + 2'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
